// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer controller: FSM state codes,
// display glyph codes and a constant-time binary-to-BCD helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ARMED  = 3'd2,
        RESULT = 3'd3,
        EARLY  = 3'd4,
        MISS   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [3:0] GLYPH_H     = 4'ha;
    localparam logic [3:0] GLYPH_I     = 4'hb;
    localparam logic [3:0] GLYPH_BLANK = 4'hc;

    localparam int MAX_DIGITS = 6;

    // Elaboration-time conversion of an integer constant to packed BCD.
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
        logic [4*MAX_DIGITS-1:0] result;
        int unsigned             rem;
        result = '0;
        rem    = value;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            result[4*d +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit packed-BCD up-counter with synchronous clear and a cascaded
// decimal carry; digit 0 occupies bits [3:0].
module bcd_counter
    import reaction_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    i_clr,
    input  logic                    i_inc,
    output logic [4*NUM_DIGITS-1:0] o_value
);

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [4*NUM_DIGITS-1:0] w_next;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic carry;
        carry  = i_inc;
        w_next = r_value;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                w_next[4*d +: 4] = (r_value[4*d +: 4] == 4'd9) ? 4'd0 : r_value[4*d +: 4] + 4'd1;
            end
            carry = carry && (r_value[4*d +: 4] == 4'd9);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Multi-trial reaction-timer controller: HI prompt, random fore-period, LED stimulus,
// ms-resolution BCD timing, early/miss detection and best-time tracking.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int RND_W        = 4,
    parameter int MIN_DELAY_MS = 2000,
    parameter int STEP_MS      = 250,
    parameter int TIMEOUT_MS   = 1000,
    parameter int NUM_TRIALS   = 4
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [RND_W-1:0]        rnd,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic                    led,
    output logic [3:0]              trial_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int HEX_W   = 4 * NUM_DIGITS;
    localparam int PRE_W   = $clog2(TICK_DIV);
    localparam int DLY_MAX = MIN_DELAY_MS + ((2 ** RND_W) - 1) * STEP_MS;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [PRE_W-1:0]        PRE_LAST         = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]              LAST_TRIAL       = 4'(NUM_TRIALS - 1);
    localparam logic [HEX_W-1:0]        ALL_NINES        = {NUM_DIGITS{4'h9}};
    localparam logic [4*MAX_DIGITS-1:0] TIMEOUT_BCD_FULL = to_bcd(TIMEOUT_MS);
    localparam logic [HEX_W-1:0]        TIMEOUT_BCD      = TIMEOUT_BCD_FULL[HEX_W-1:0];

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_WAIT   = 3'(WAIT);
    localparam logic [2:0] S_ARMED  = 3'(ARMED);
    localparam logic [2:0] S_RESULT = 3'(RESULT);
    localparam logic [2:0] S_EARLY  = 3'(EARLY);
    localparam logic [2:0] S_MISS   = 3'(MISS);
    localparam logic [2:0] S_DONE   = 3'(DONE);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [PRE_W-1:0] r_presc;
    logic [DLY_W-1:0] r_delay;
    logic [DLY_W-1:0] r_target;
    logic [DLY_W-1:0] w_target;
    logic [3:0]       r_trial;
    logic [HEX_W-1:0] r_best;
    logic [HEX_W-1:0] w_count;
    logic [HEX_W-1:0] w_hex;
    logic             w_tick;
    logic             w_delay_hit;
    logic             w_timeout;
    logic             w_enter_wait;
    logic             w_enter_armed;
    logic             w_sess_start;
    logic             w_trial_end;
    logic             w_bcd_inc;

    assign w_tick       = (r_presc == PRE_LAST);
    assign w_delay_hit  = (r_delay == r_target);
    assign w_timeout    = (w_count == TIMEOUT_BCD);
    assign w_target     = DLY_W'(MIN_DELAY_MS + int'(rnd) * STEP_MS);
    assign w_sess_start = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_trial_end  = (r_state == S_RESULT) || (r_state == S_EARLY) || (r_state == S_MISS);

    // Stop is checked before the timer conditions, so a same-cycle stop always wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_WAIT;
            S_WAIT: begin
                if (stop)             w_next = S_EARLY;
                else if (w_delay_hit) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (stop)           w_next = S_RESULT;
                else if (w_timeout) w_next = S_MISS;
            end
            S_RESULT, S_EARLY, S_MISS: begin
                if (start) w_next = (r_trial == LAST_TRIAL) ? S_DONE : S_WAIT;
            end
            S_DONE:   if (start) w_next = S_WAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_enter_wait  = (w_next == S_WAIT)  && (r_state != S_WAIT);
    assign w_enter_armed = (w_next == S_ARMED) && (r_state != S_ARMED);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter_wait || w_enter_armed || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_delay  <= '0;
            r_target <= '0;
        end else if (w_enter_wait) begin
            r_delay  <= '0;
            r_target <= w_target;
        end else if (r_state == S_WAIT && w_tick) begin
            r_delay  <= r_delay + DLY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_trial <= '0;
            r_best  <= ALL_NINES;
        end else if (w_sess_start) begin
            r_trial <= '0;
            r_best  <= ALL_NINES;
        end else begin
            if (start && w_trial_end && r_trial != LAST_TRIAL) begin
                r_trial <= r_trial + 4'd1;
            end
            // Packed BCD orders the same as the decimal value, so a plain compare suffices.
            if (r_state == S_RESULT && w_count < r_best) begin
                r_best <= w_count;
            end
        end
    end

    assign w_bcd_inc = (r_state == S_ARMED) && w_tick && !stop && !w_timeout;

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_ms_count (
        .clk     (clk),
        .clear_n (clear_n),
        .i_clr   (w_enter_armed),
        .i_inc   (w_bcd_inc),
        .o_value (w_count)
    );

    always_comb begin
        w_hex = {NUM_DIGITS{GLYPH_BLANK}};
        case (r_state)
            S_IDLE: begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (d == NUM_DIGITS - 1)      w_hex[4*d +: 4] = GLYPH_H;
                    else if (d == NUM_DIGITS - 2) w_hex[4*d +: 4] = GLYPH_I;
                end
            end
            S_RESULT: w_hex = w_count;
            S_EARLY:  w_hex = ALL_NINES;
            S_MISS:   w_hex = TIMEOUT_BCD;
            S_DONE:   w_hex = r_best;
            default:  ;
        endcase
    end

    assign hex_out   = w_hex;
    assign led       = (r_state == S_ARMED);
    assign busy      = (r_state == S_WAIT) || (r_state == S_ARMED);
    assign done      = (r_state == S_DONE);
    assign trial_idx = r_trial;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a 4-cycle ms tick: a transition table
// plus hand-timed sequences for fore-period, timing, timeout and best tracking.
module tb_reaction_timer_ctrl;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic        stop;
    logic [3:0]  rnd;
    logic [15:0] hex_out;
    logic        led;
    logic [3:0]  trial_idx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    reaction_timer_ctrl #(
        .NUM_DIGITS   (4),
        .TICK_DIV     (4),
        .RND_W        (4),
        .MIN_DELAY_MS (2),
        .STEP_MS      (1),
        .TIMEOUT_MS   (20),
        .NUM_TRIALS   (2)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .stop      (stop),
        .rnd       (rnd),
        .hex_out   (hex_out),
        .led       (led),
        .trial_idx (trial_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic [3:0]  rnd;
        logic [15:0] hex;
        logic        led;
        logic        busy;
        logic        done;
        logic [3:0]  trial;
    } vec_t;

    localparam int NUM_VEC = 10;
    vec_t vecs [NUM_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_hex, input logic e_led,
                             input logic e_busy, input logic e_done, input logic [3:0] e_trial);
        check({tag, "_hex"},   32'(hex_out),   32'(e_hex));
        check({tag, "_led"},   32'(led),       32'(e_led));
        check({tag, "_busy"},  32'(busy),      32'(e_busy));
        check({tag, "_done"},  32'(done),      32'(e_done));
        check({tag, "_trial"}, 32'(trial_idx), 32'(e_trial));
    endtask

    // Called at a falling edge; inputs are held across exactly one rising edge.
    task automatic pulse(input logic s, input logic p, input logic [3:0] r);
        start = s;
        stop  = p;
        rnd   = r;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Returns at the first falling edge that sees the LED lit.
    task automatic wait_led(input string tag, input int max_cyc);
        int n = 0;
        while (led !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_led_rise"}, 32'(led), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'd0, 16'hABCC, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b1, 1'b0, 4'd0, 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[2] = '{1'b0, 1'b1, 4'd0, 16'h9999, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{1'b0, 1'b1, 4'd0, 16'h9999, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{1'b1, 1'b0, 4'd0, 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[5] = '{1'b1, 1'b0, 4'd0, 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[6] = '{1'b0, 1'b1, 4'd0, 16'h9999, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[7] = '{1'b1, 1'b0, 4'd0, 16'h9999, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[8] = '{1'b0, 1'b1, 4'd0, 16'h9999, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[9] = '{1'b1, 1'b0, 4'd3, 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd0};

        clear_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        rnd     = 4'd0;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check_out("reset", 16'hABCC, 1'b0, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < NUM_VEC; i++) begin
            pulse(vecs[i].start, vecs[i].stop, vecs[i].rnd);
            check_out($sformatf("vec%0d", i), vecs[i].hex, vecs[i].led,
                      vecs[i].busy, vecs[i].done, vecs[i].trial);
        end

        // rnd=3 fore-period is 5 ms = 20 cycles; LED must be dark at 18 and lit by 22.
        repeat (18) @(negedge clk);
        check("h1_led_dark_18", 32'(led), 32'd0);
        wait_led("h1", 4);
        repeat (28) @(negedge clk);
        pulse(1'b0, 1'b1, 4'd3);
        check_out("h1_result7", 16'h0007, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b1, 1'b0, 4'd3);
        pulse(1'b0, 1'b1, 4'd3);
        check_out("h1_early", 16'h9999, 1'b0, 1'b0, 1'b0, 4'd1);
        pulse(1'b1, 1'b0, 4'd3);
        check_out("h1_done", 16'h0007, 1'b0, 1'b0, 1'b1, 4'd1);

        // Session: 12 then 9; best must become 9.
        pulse(1'b1, 1'b0, 4'd0);
        wait_led("h2a", 100);
        repeat (48) @(negedge clk);
        pulse(1'b0, 1'b1, 4'd0);
        check_out("h2_result12", 16'h0012, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b1, 1'b0, 4'd0);
        wait_led("h2b", 100);
        repeat (36) @(negedge clk);
        pulse(1'b0, 1'b1, 4'd0);
        check_out("h2_result9", 16'h0009, 1'b0, 1'b0, 1'b0, 4'd1);
        pulse(1'b1, 1'b0, 4'd0);
        check_out("h2_done", 16'h0009, 1'b0, 1'b0, 1'b1, 4'd1);

        // Session: EARLY then MISS; best stays all nines.
        pulse(1'b1, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 4'd0);
        check_out("h3_early", 16'h9999, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b1, 1'b0, 4'd0);
        check_out("h3_wait1", 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd1);
        wait_led("h3", 100);
        repeat (80) @(negedge clk);
        check_out("h3_armed_at_20", 16'hCCCC, 1'b1, 1'b1, 1'b0, 4'd1);
        @(negedge clk);
        check_out("h3_miss", 16'h0020, 1'b0, 1'b0, 1'b0, 4'd1);
        pulse(1'b1, 1'b0, 4'd0);
        check_out("h3_done", 16'h9999, 1'b0, 1'b0, 1'b1, 4'd1);

        // Session: stop coincident with the 20th tick, then start+stop together in ARMED.
        pulse(1'b1, 1'b0, 4'd0);
        wait_led("h4a", 100);
        repeat (79) @(negedge clk);
        pulse(1'b0, 1'b1, 4'd0);
        check_out("h4_result19", 16'h0019, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b1, 1'b0, 4'd0);
        wait_led("h4b", 100);
        repeat (12) @(negedge clk);
        pulse(1'b1, 1'b1, 4'd0);
        check_out("h4_start_stop", 16'h0003, 1'b0, 1'b0, 1'b0, 4'd1);
        pulse(1'b1, 1'b0, 4'd0);
        check_out("h4_done", 16'h0003, 1'b0, 1'b0, 1'b1, 4'd1);

        // Asynchronous clear in the middle of ARMED on trial 1.
        pulse(1'b1, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 4'd0);
        pulse(1'b1, 1'b0, 4'd0);
        wait_led("h5", 100);
        repeat (5) @(negedge clk);
        check("h5_trial_before_clear", 32'(trial_idx), 32'd1);
        #2 clear_n = 1'b0;
        #1 check_out("h5_clear_async", 16'hABCC, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check_out("h5_idle_after", 16'hABCC, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
